// File: rtl/forthsuper_mem_pkg.sv
// Shared types and helpers for the Forth core memory access unit.
package forthsuper_mem_pkg;

  // Access size encoding as presented by the core; 2'b11 is handled as a word.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_sz_t;

  // Sequencer states: idle/first store word, load first word, load second word,
  // store second word.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LD1  = 2'b01,
    LD2  = 2'b10,
    ST2  = 2'b11
  } mau_state_t;

  localparam int unsigned LANES = 4;

  // Unshifted byte-lane mask for an access size (lane 0 = least significant byte).
  function automatic logic [3:0] size_lanes(input logic [1:0] sz);
    logic [3:0] m;
    if (sz == SZ_B) begin
      m = 4'b0001;
    end else if (sz == SZ_H) begin
      m = 4'b0011;
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: byte-lane masks across two words, store data
// placement and load data extraction with zero extension.
module mau_lane_align
  import forthsuper_mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  sz_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  lm8_o,
  output logic [63:0] wide64_o,
  output logic [31:0] ld_o
);

  logic [3:0]  lanes;
  logic [4:0]  shamt;
  logic [63:0] st_raw;
  logic [31:0] ld_raw;
  logic [31:0] ld_keep;

  // Derive the lane mask and shifted store/load words from the byte offset.
  always_comb begin
    lanes  = size_lanes(sz_i);
    shamt  = {off_i, 3'b000};
    lm8_o  = {4'b0000, lanes} << off_i;
    st_raw = {32'h0000_0000, wd_i} << shamt;
    ld_raw = 32'({hi_i, lo_i} >> shamt);
  end

  // Per-lane masking: store lanes outside the access drive zero, load bytes
  // beyond the access size are cleared to zero-extend.
  for (genvar gi = 0; gi < 8; gi++) begin : g_st_lane
    assign wide64_o[8*gi +: 8] = lm8_o[gi] ? st_raw[8*gi +: 8] : 8'h00;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_ld_lane
    assign ld_keep[8*gi +: 8] = {8{lanes[gi]}};
  end

  assign ld_o = ld_raw & ld_keep;

endmodule

// File: rtl/spram_mau.sv
// Memory access unit: turns byte/half/word loads and stores at arbitrary byte
// addresses into one or two lane-masked cycles on a 32-bit single-port SRAM.
module spram_mau
  import forthsuper_mem_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        sz,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic              rdy,
  output logic              rvalid,
  output logic [31:0]       rd,
  output logic              m_we,
  output logic [3:0]        m_bmsk,
  output logic [ADDR_W-3:0] m_a,
  output logic [31:0]       m_vi,
  input  logic [31:0]       m_vo
);

  localparam int WA_W = ADDR_W - 2;

  mau_state_t      state_q, state_d;
  logic [1:0]      sz_q;
  logic [1:0]      off_q;
  logic [WA_W-1:0] w_q;
  logic [WA_W-1:0] w_next;
  logic [31:0]     wd_q;
  logic [31:0]     lo_q;
  logic [31:0]     rd_q;
  logic            rvalid_q;

  logic            idle;
  logic            accept;
  logic            split;
  logic [1:0]      al_off;
  logic [1:0]      al_sz;
  logic [31:0]     al_wd;
  logic [31:0]     al_lo;
  logic [31:0]     al_hi;
  logic [7:0]      lm8;
  logic [63:0]     wide64;
  logic [31:0]     ld_data;

  assign idle   = (state_q == IDLE);
  assign accept = req & idle;
  assign split  = |lm8[7:4];
  // Second word wraps around the top of the SRAM.
  assign w_next = w_q + WA_W'(1);

  // Aligner sees the live request while idle and the latched one afterwards;
  // load words come from m_vo (first word) or lo_q plus m_vo (split).
  always_comb begin
    al_off = idle ? a[1:0] : off_q;
    al_sz  = idle ? sz : sz_q;
    al_wd  = idle ? wd : wd_q;
    al_lo  = (state_q == LD2) ? lo_q : m_vo;
    al_hi  = (state_q == LD2) ? m_vo : 32'h0000_0000;
  end

  mau_lane_align u_align (
    .off_i   (al_off),
    .sz_i    (al_sz),
    .wd_i    (al_wd),
    .lo_i    (al_lo),
    .hi_i    (al_hi),
    .lm8_o   (lm8),
    .wide64_o(wide64),
    .ld_o    (ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stores finish in IDLE unless split, loads go through LD1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (we) begin
            state_d = split ? ST2 : IDLE;
          end else begin
            state_d = LD1;
          end
        end
      end
      LD1:     state_d = split ? LD2 : IDLE;
      LD2:     state_d = IDLE;
      ST2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM-side outputs; writes are suppressed while reset is asserted.
  always_comb begin
    rdy    = 1'b0;
    m_we   = 1'b0;
    m_bmsk = 4'b0000;
    m_a    = w_q;
    m_vi   = 32'h0000_0000;
    unique case (state_q)
      IDLE: begin
        rdy = 1'b1;
        m_a = a[ADDR_W-1:2];
        if (req && we && !rst) begin
          m_we   = 1'b1;
          m_bmsk = lm8[3:0];
          m_vi   = wide64[31:0];
        end
      end
      LD1: begin
        if (split) begin
          m_a = w_next;
        end
      end
      LD2: begin
        m_a = w_next;
      end
      ST2: begin
        m_a = w_next;
        if (!rst) begin
          m_we   = 1'b1;
          m_bmsk = lm8[7:4];
          m_vi   = wide64[63:32];
        end
      end
      default: begin
        rdy = 1'b0;
      end
    endcase
  end

  // Request latches, first load word capture and registered load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sz_q     <= 2'b00;
      off_q    <= 2'b00;
      w_q      <= '0;
      wd_q     <= 32'h0000_0000;
      lo_q     <= 32'h0000_0000;
      rd_q     <= 32'h0000_0000;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept) begin
        sz_q  <= sz;
        off_q <= a[1:0];
        w_q   <= a[ADDR_W-1:2];
        wd_q  <= wd;
      end
      if (state_q == LD1) begin
        lo_q <= m_vo;
        if (!split) begin
          rd_q     <= ld_data;
          rvalid_q <= 1'b1;
        end
      end
      if (state_q == LD2) begin
        rd_q     <= ld_data;
        rvalid_q <= 1'b1;
      end
    end
  end

  assign rd     = rd_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_spram_mau.sv
// Bench for spram_mau with a behavioural 32Kx32 lane-masked SRAM.
module tb_spram_mau;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  sz;
  logic [16:0] a;
  logic [31:0] wd;
  logic        rdy;
  logic        rvalid;
  logic [31:0] rd;
  logic        m_we;
  logic [3:0]  m_bmsk;
  logic [14:0] m_a;
  logic [31:0] m_vi;
  logic [31:0] m_vo;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:32767];

  always #5 clk = ~clk;

  spram_mau #(.ADDR_W(17)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .sz    (sz),
    .a     (a),
    .wd    (wd),
    .rdy   (rdy),
    .rvalid(rvalid),
    .rd    (rd),
    .m_we  (m_we),
    .m_bmsk(m_bmsk),
    .m_a   (m_a),
    .m_vi  (m_vi),
    .m_vo  (m_vo)
  );

  // SRAM model: registered read, lane-masked write.
  always @(posedge clk) begin
    if (m_we) begin
      for (int i = 0; i < 4; i++) begin
        if (m_bmsk[i]) mem[m_a][8*i +: 8] <= m_vi[8*i +: 8];
      end
    end
    m_vo <= mem[m_a];
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [16:0] a;
    logic [31:0] wd;
    logic        split;
    logic [14:0] a0;
    logic [3:0]  m0;
    logic [31:0] v0;
    logic [14:0] a1;
    logic [3:0]  m1;
    logic [31:0] v1;
    logic [31:0] rdx;
    int          lat;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk_st(input logic [1:0] s, input logic [16:0] ad, input logic [31:0] d,
                                 input logic sp, input logic [14:0] a0, input logic [3:0] m0,
                                 input logic [31:0] v0, input logic [14:0] a1, input logic [3:0] m1,
                                 input logic [31:0] v1);
    vec_t v;
    v.we = 1'b1; v.sz = s; v.a = ad; v.wd = d; v.split = sp;
    v.a0 = a0; v.m0 = m0; v.v0 = v0; v.a1 = a1; v.m1 = m1; v.v1 = v1;
    v.rdx = 32'h0; v.lat = 0;
    return v;
  endfunction

  function automatic vec_t mk_ld(input logic [1:0] s, input logic [16:0] ad,
                                 input logic [31:0] r, input int l);
    vec_t v;
    v.we = 1'b0; v.sz = s; v.a = ad; v.wd = 32'h0; v.split = 1'b0;
    v.a0 = 15'h0; v.m0 = 4'h0; v.v0 = 32'h0; v.a1 = 15'h0; v.m1 = 4'h0; v.v1 = 32'h0;
    v.rdx = r; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Apply one transaction starting in an idle cycle and check every cycle of it.
  task automatic do_txn(input int idx, input vec_t v);
    int cyc;
    bit got;
    req = 1'b1; we = v.we; sz = v.sz; a = v.a; wd = v.wd;
    @(negedge clk);
    chk("accept_rdy", 32'(rdy), 32'd1);
    chk("t0_m_we", 32'(m_we), 32'(v.we));
    if (v.we) begin
      chk("t0_m_a", 32'(m_a), 32'(v.a0));
      chk("t0_m_bmsk", 32'(m_bmsk), 32'(v.m0));
      chk("t0_m_vi", m_vi, v.v0);
    end
    next_cycle();
    req = 1'b0;
    if (v.we) begin
      @(negedge clk);
      chk("t1_m_we", 32'(m_we), 32'(v.split));
      chk("t1_rdy", 32'(rdy), 32'(!v.split));
      if (v.split) begin
        chk("t1_m_a", 32'(m_a), 32'(v.a1));
        chk("t1_m_bmsk", 32'(m_bmsk), 32'(v.m1));
        chk("t1_m_vi", m_vi, v.v1);
      end
      next_cycle();
      $display("txn %0d store sz=%0d a=%05h wd=%08h split=%0d", idx, v.sz, v.a, v.wd, v.split);
    end else begin
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < 8) begin
        @(negedge clk);
        if (rvalid === 1'b1) begin
          got = 1'b1;
        end else begin
          chk("ld_busy_no_we", 32'(m_we), 32'd0);
          next_cycle();
          cyc++;
        end
      end
      chk("ld_rvalid_seen", 32'(got), 32'd1);
      chk("ld_latency", 32'(cyc), 32'(v.lat));
      chk("ld_rd", rd, v.rdx);
      chk("ld_rdy_with_rvalid", 32'(rdy), 32'd1);
      next_cycle();
      $display("txn %0d load sz=%0d a=%05h rd=%08h lat=%0d", idx, v.sz, v.a, rd, cyc);
    end
  endtask

  int pulses;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    rst = 1'b1; req = 1'b1; we = 1'b1; sz = 2'b10; a = 17'h00010; wd = 32'h12345678;

    vt[0]  = mk_st(2'b10, 17'h00010, 32'hDEADBEEF, 1'b0, 15'h0004, 4'b1111, 32'hDEADBEEF, 15'h0, 4'h0, 32'h0);
    vt[1]  = mk_ld(2'b10, 17'h00010, 32'hDEADBEEF, 2);
    vt[2]  = mk_ld(2'b00, 17'h00013, 32'h000000DE, 2);
    vt[3]  = mk_ld(2'b01, 17'h00012, 32'h0000DEAD, 2);
    vt[4]  = mk_st(2'b10, 17'h00005, 32'h11223344, 1'b1, 15'h0001, 4'b1110, 32'h22334400, 15'h0002, 4'b0001, 32'h00000011);
    vt[5]  = mk_ld(2'b10, 17'h00005, 32'h11223344, 3);
    vt[6]  = mk_st(2'b01, 17'h1FFFF, 32'h0000ABCD, 1'b1, 15'h7FFF, 4'b1000, 32'hCD000000, 15'h0000, 4'b0001, 32'h000000AB);
    vt[7]  = mk_ld(2'b01, 17'h1FFFF, 32'h0000ABCD, 3);
    vt[8]  = mk_st(2'b00, 17'h00022, 32'hFFFFFF5A, 1'b0, 15'h0008, 4'b0100, 32'h005A0000, 15'h0, 4'h0, 32'h0);
    vt[9]  = mk_ld(2'b10, 17'h00020, 32'h005A0000, 2);
    vt[10] = mk_st(2'b00, 17'h00023, 32'h00000077, 1'b0, 15'h0008, 4'b1000, 32'h77000000, 15'h0, 4'h0, 32'h0);
    vt[11] = mk_ld(2'b01, 17'h00022, 32'h0000775A, 2);
    vt[12] = mk_st(2'b11, 17'h00030, 32'hCAFEF00D, 1'b0, 15'h000C, 4'b1111, 32'hCAFEF00D, 15'h0, 4'h0, 32'h0);
    vt[13] = mk_ld(2'b11, 17'h00031, 32'h00CAFEF0, 3);
    vt[14] = mk_st(2'b01, 17'h00011, 32'h00001234, 1'b0, 15'h0004, 4'b0110, 32'h00123400, 15'h0, 4'h0, 32'h0);
    vt[15] = mk_ld(2'b10, 17'h00010, 32'hDE1234EF, 2);
    vt[16] = mk_ld(2'b00, 17'h00011, 32'h00000034, 2);
    vt[17] = mk_ld(2'b00, 17'h00000, 32'h000000AB, 2);

    // Reset state: a store request during reset must not reach the SRAM.
    @(negedge clk);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_bmsk", 32'(m_bmsk), 32'd0);
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rd", rd, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(rdy), 32'd1);
    chk("post_rst_mem_untouched", mem[4], 32'd0);
    next_cycle();

    for (int i = 0; i < 18; i++) do_txn(i, vt[i]);

    // Reset during the second half of a split store.
    do_txn(100, mk_st(2'b10, 17'h00004, 32'hAAAAAAAA, 1'b0, 15'h0001, 4'b1111, 32'hAAAAAAAA, 15'h0, 4'h0, 32'h0));
    do_txn(101, mk_st(2'b10, 17'h00008, 32'hBBBBBBBB, 1'b0, 15'h0002, 4'b1111, 32'hBBBBBBBB, 15'h0, 4'h0, 32'h0));
    req = 1'b1; we = 1'b1; sz = 2'b10; a = 17'h00005; wd = 32'h11223344;
    @(negedge clk);
    chk("rs_t0_m_we", 32'(m_we), 32'd1);
    next_cycle();
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rs_t1_m_we", 32'(m_we), 32'd0);
    chk("rs_t1_m_bmsk", 32'(m_bmsk), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_rdy", 32'(rdy), 32'd1);
    chk("rs_rvalid", 32'(rvalid), 32'd0);
    next_cycle();
    $display("txn 102 split store a=00005 interrupted by reset");
    do_txn(103, mk_ld(2'b10, 17'h00004, 32'h223344AA, 2));
    do_txn(104, mk_ld(2'b10, 17'h00008, 32'hBBBBBBBB, 2));

    // Reset while a load is pending: no rvalid afterwards.
    req = 1'b1; we = 1'b0; sz = 2'b10; a = 17'h00010;
    next_cycle();
    req = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1) pulses++;
      next_cycle();
    end
    chk("rl_no_rvalid", 32'(pulses), 32'd0);
    $display("txn 105 load a=00010 interrupted by reset pulses=%0d", pulses);

    // Back-to-back loads: second request held while busy, accepted with first rvalid.
    req = 1'b1; we = 1'b0; sz = 2'b10; a = 17'h00010;
    @(negedge clk);
    chk("bb_t0_rdy", 32'(rdy), 32'd1);
    next_cycle();
    a = 17'h00020; sz = 2'b10;
    @(negedge clk);
    chk("bb_t1_rdy", 32'(rdy), 32'd0);
    chk("bb_t1_rvalid", 32'(rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("bb_t2_rdy", 32'(rdy), 32'd1);
    chk("bb_t2_rvalid", 32'(rvalid), 32'd1);
    chk("bb_t2_rd", rd, 32'hDE1234EF);
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    chk("bb_t3_rvalid", 32'(rvalid), 32'd0);
    chk("bb_t3_rd_hold", rd, 32'hDE1234EF);
    next_cycle();
    @(negedge clk);
    chk("bb_t4_rvalid", 32'(rvalid), 32'd1);
    chk("bb_t4_rd", rd, 32'h775A0000);
    next_cycle();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1) pulses++;
      next_cycle();
    end
    chk("bb_no_dup", 32'(pulses), 32'd0);
    $display("txn 106 back-to-back loads a=00010,00020 rd=%08h", rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
